// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the shift-and-add multiplier.
//   - state_t : control FSM encoding (IDLE, RUN, DONE)
//   - MULT_N  : default operand width
//   - cnt_w() : iteration counter width for an N-bit operand (min 1)
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MULT_N = 4;

    // Counter must hold 0..N-1; a single-bit counter is the floor.
    function automatic int cnt_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : mult_pkg

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: N-bit unsigned ripple-carry adder.
// Ports:
//   A, B  (in,  N) addends
//   Cin   (in,  1) carry in
//   Sum   (out, N) A + B + Cin, low N bits
//   Cout  (out, 1) carry out of the top bit
module ripple_carry_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout
);

    logic [N:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign Sum[i]  = A[i] ^ B[i] ^ c[i];
        assign c[i+1]  = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign Cout = c[N];

endmodule : ripple_carry_adder

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned N x N -> 2N multiplier using
// shift-and-add, one partial-product step per clock through a single
// ripple_carry_adder.
// Ports:
//   clk        (in,  1)  rising-edge clock
//   rst        (in,  1)  synchronous active-high reset
//   in_valid   (in,  1)  operands A/B valid
//   in_ready   (out, 1)  operands accepted this cycle (IDLE only)
//   A          (in,  N)  multiplicand, unsigned
//   B          (in,  N)  multiplier, unsigned
//   out_valid  (out, 1)  Product valid (DONE)
//   out_ready  (in,  1)  consumer takes Product
//   Product    (out, 2N) A*B, unsigned
// Build option: define MULT_ZERO_SKIP_EN to bypass the iterations when
// either operand is zero (result ready the cycle after accept).
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] Product
);

    localparam int               CNT_W = cnt_w(N);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

    state_t           state;
    logic [N-1:0]     mcand;
    logic [2*N-1:0]   p;
    logic [CNT_W-1:0] cnt;

    logic [N-1:0]     add_sum;
    logic             add_cout;
    logic             step_c;
    logic [N-1:0]     step_hi;

    // Add stage: upper half of P plus the multiplicand.
    ripple_carry_adder #(.N(N)) u_add (
        .A    (p[2*N-1:N]),
        .B    (mcand),
        .Cin  (1'b0),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    // Take the sum only when the current multiplier bit is set; the adder
    // carry becomes the new MSB so no bit of the product is ever lost.
    always_comb begin
        step_c  = 1'b0;
        step_hi = p[2*N-1:N];
        if (p[0]) begin
            step_c  = add_cout;
            step_hi = add_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mcand     <= '0;
            p         <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= A;
                        cnt      <= '0;
                        in_ready <= 1'b0;
`ifdef MULT_ZERO_SKIP_EN
                        if (A == '0 || B == '0) begin
                            p         <= '0;
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            p     <= {{N{1'b0}}, B};
                            state <= RUN;
                        end
`else
                        p     <= {{N{1'b0}}, B};
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    p   <= {step_c, step_hi, p[N-1:1]};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // P is left untouched so Product keeps the result.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign Product = p;

endmodule : shift_add_multiplier

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (N = 4).
module tb_shift_add_multiplier;

    localparam int N = 4;

`ifdef MULT_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] Product;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    shift_add_multiplier #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Product   (Product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: result = A*B, available N cycles after the
    // accept edge (or immediately for a zero operand in the skip build),
    // held until out_ready; Product keeps its last result while idle.
    logic           m_rdy;
    logic           m_vld;
    logic [2*N-1:0] m_prod;
    logic [2*N-1:0] m_pend;
    int             m_left;

    always @(posedge clk) begin
        if (rst) begin
            m_rdy  <= 1'b1;
            m_vld  <= 1'b0;
            m_prod <= '0;
            m_pend <= '0;
            m_left <= 0;
        end else if (m_rdy && in_valid) begin
            m_rdy  <= 1'b0;
            m_pend <= (2*N)'(int'(A) * int'(B));
            if (ZS && (A == 0 || B == 0)) begin
                m_vld  <= 1'b1;
                m_prod <= '0;
            end else begin
                m_left <= N;
            end
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_vld  <= 1'b1;
                m_prod <= m_pend;
            end
        end else if (m_vld && out_ready) begin
            m_vld <= 1'b0;
            m_rdy <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready", 64'(in_ready), 64'(m_rdy));
            chk("out_valid", 64'(out_valid), 64'(m_vld));
            if (m_vld || m_rdy)
                chk("Product", 64'(Product), 64'(m_prod));
        end
    end

    // Wait for out_valid; returns the number of clock edges after the
    // accept edge before it was seen.
    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (out_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: out_valid never rose within 50 cycles");
        end
    endtask

    // Present A/B while idle, check latency and result, optionally stall
    // the consumer for hold cycles, then complete the handshake.
    task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2*N-1:0] exp, input int exp_lat, input int hold);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        A         = a;
        B         = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A        = $urandom_range(0, 15);
        B        = $urandom_range(0, 15);
        wait_valid(n);
        chk({name, "_latency"}, 64'(n), 64'(exp_lat));
        chk({name, "_product"}, 64'(Product), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({name, "_hold_vld"}, 64'(out_valid), 64'd1);
            chk({name, "_hold_rdy"}, 64'(in_ready), 64'd0);
            chk({name, "_hold_prod"}, 64'(Product), 64'(exp));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({name, "_idle_vld"}, 64'(out_valid), 64'd0);
        chk({name, "_idle_rdy"}, 64'(in_ready), 64'd1);
        chk({name, "_idle_prod"}, 64'(Product), 64'(exp));
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_product", 64'(Product), 64'd0);
        cmp_en = 1'b1;

        run_op("m3x5",   4'd3,  4'd5,  8'h0F, N, 0);
        run_op("m15x15", 4'd15, 4'd15, 8'hE1, N, 0);
        run_op("m10x6",  4'd10, 4'd6,  8'h3C, N, 3);
        run_op("m0x9",   4'd0,  4'd9,  8'h00, ZS ? 0 : N, 0);
        run_op("m7x0",   4'd7,  4'd0,  8'h00, ZS ? 0 : N, 0);
        run_op("m11x13", 4'd11, 4'd13, 8'h8F, N, 1);

        // Reset in the middle of a run discards the operation.
        in_valid = 1'b1;
        A        = 4'd12;
        B        = 4'd13;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_vld", 64'(out_valid), 64'd0);
        chk("rst_mid_rdy", 64'(in_ready), 64'd1);
        chk("rst_mid_prod", 64'(Product), 64'd0);
        run_op("m2x3", 4'd2, 4'd3, 8'h06, N, 0);

        // Operands presented while busy are ignored until IDLE returns.
        in_valid = 1'b1;
        A        = 4'd9;
        B        = 4'd9;
        @(posedge clk); #1;
        A = 4'd1;
        B = 4'd1;
        wait_valid(n);
        chk("busy_latency", 64'(n), 64'(N));
        chk("busy_first", 64'(Product), 64'h51);
        @(posedge clk); #1;
        chk("busy_idle_rdy", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_second_accept", 64'(in_ready), 64'd0);
        wait_valid(n);
        chk("busy_second", 64'(Product), 64'h01);
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_shift_add_multiplier
